// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings for the MEM stage
package mem_stage_pkg;

  localparam logic ResetEnable  = 1'b1;
  localparam logic ResetDisable = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam int MemOp_Len = 4;

  typedef enum logic [MemOp_Len-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: passthrough for ALU ops, byte-serial loads/stores on an 8-bit port
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_enable_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_req_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_enable_o
);

  mem_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] asm_q, asm_d;

  function automatic logic is_mem_op(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
      MEM_SB, MEM_SH, MEM_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Index of the final byte: 0 for byte ops, 1 for halves, 3 for words.
  function automatic logic [1:0] last_byte(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 2'd0;
      MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
      default:                 return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] load_result(input logic [3:0] op, input logic [31:0] w);
    case (op)
      MEM_LB:  return {{24{w[7]}}, w[7:0]};
      MEM_LH:  return {{16{w[15]}}, w[15:0]};
      MEM_LBU: return {24'h0, w[7:0]};
      MEM_LHU: return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      op_q    <= MEM_NONE;
      asm_q   <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    op_d    = op_q;
    asm_d   = asm_q;
    case (state_q)
      ST_IDLE: begin
        if (is_mem_op(mem_op_i)) begin
          state_d = ST_ACCESS;
          cnt_d   = 2'd0;
          last_d  = last_byte(mem_op_i);
          op_d    = mem_op_i;
          asm_d   = ZERO_WORD;
        end
      end
      ST_ACCESS: begin
        if (mem_ack_i) begin
          if (!is_store(op_q)) asm_d[{cnt_q, 3'b000} +: 8] = mem_rdata_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = WriteDisable;
    mem_addr_o  = '0;
    mem_wdata_o = 8'h00;
    stall_req_o = 1'b0;
    rd_data_o   = ZERO_WORD;
    rd_addr_o   = 5'd0;
    rd_enable_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mem_op(mem_op_i)) begin
          stall_req_o = 1'b1;
        end else begin
          rd_data_o   = rd_data_i;
          rd_addr_o   = rd_addr_i;
          rd_enable_o = rd_enable_i;
        end
      end
      ST_ACCESS: begin
        mem_req_o   = 1'b1;
        stall_req_o = 1'b1;
        mem_addr_o  = mem_addr_i + ADDR_W'(cnt_q);
        if (is_store(op_q)) begin
          mem_we_o    = WriteEnable;
          mem_wdata_o = store_data_i[{cnt_q, 3'b000} +: 8];
        end
      end
      ST_DONE: begin
        rd_addr_o = rd_addr_i;
        if (!is_store(op_q)) begin
          rd_data_o   = load_result(op_q, asm_q);
          rd_enable_o = rd_enable_i;
        end
      end
      default: ;
    endcase
  end

endmodule
